cordic_result_router: RTL and testbench
=======================================

Name: cordic_result_router

Overview:
- Return path of the shared CORDIC. Routes each vectoring or rotation result back to the client block that issued it: GSO, normalization, update or estimation.
- Issue strobes and the block select are taken at the CORDIC input side. A per-mode tag FIFO records the issuer of every in-flight operation.
- Results are held in per-client registers with a valid/ack handshake, so a client may consume a result at any time after completion.

Parameters:
- DATA_WIDTH, 16, width of x/y/magnitude results
- ANGLE_WIDTH, 16, width of vectoring angle result
- CORDIC_STAGES, 16, width of micro-rotation direction vector
- TAG_DEPTH, 4, maximum in-flight operations per mode; power of 2, at least 2

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- block  in  2  issuing client: 00 GSO, 01 norm, 10 updt, 11 est
- flush  in  1  synchronous clear of tags, valids and error flags
- cordic_vec_en  in  1  one-cycle vectoring issue strobe
- cordic_rot_en  in  1  one-cycle rotation issue strobe
- cordic_vec_done  in  1  one-cycle vectoring completion strobe
- cordic_vec_xout  in  DATA_WIDTH  vectoring magnitude
- cordic_vec_angle_out  in  ANGLE_WIDTH  vectoring angle
- cordic_vec_microRot_out  in  CORDIC_STAGES  micro-rotation directions
- cordic_rot_done  in  1  one-cycle rotation completion strobe
- cordic_rot_xout  in  DATA_WIDTH  rotated x
- cordic_rot_yout  in  DATA_WIDTH  rotated y
- vec_ack  in  4  per-client consume strobe; bit i = client i
- rot_ack  in  4  per-client consume strobe
- vec_vld  out  4  per-client vectoring result valid
- vec_mag  out  4*DATA_WIDTH  slot i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- vec_angle  out  4*ANGLE_WIDTH  per-client angle
- vec_microRot  out  4*CORDIC_STAGES  per-client micro-rotation vector
- rot_vld  out  4  per-client rotation result valid
- rot_xout  out  4*DATA_WIDTH  per-client rotated x
- rot_yout  out  4*DATA_WIDTH  per-client rotated y
- vec_ovf, rot_ovf  out  4 each  sticky: an unacked result was overwritten
- err_tagfull  out  1  sticky: issue while tag FIFO full
- err_orphan  out  1  sticky: done with tag FIFO empty
- busy  out  1  either tag FIFO non-empty

Behaviour:
- Reset (rst=1, async): FIFO pointers and counts 0; all vld, ovf, err and data outputs 0; busy 0.
- Two independent tag FIFOs (vec, rot), each TAG_DEPTH x 2 bits, with separate read/write pointers and a count. Pointers wrap modulo TAG_DEPTH.
- Issue: on cordic_X_en=1, push `block`. If the FIFO is full and no pop occurs that cycle, drop the tag and set err_tagfull.
- Completion: on cordic_X_done=1 with FIFO non-empty, pop tag t.
  - Register the result fields into slot t.
  - Set X_vld[t] on the next clock edge, so results are visible 1 cycle after done.
  - If the FIFO is empty, drop the result and set err_orphan.
- Push and pop in the same cycle: both take effect and the count is unchanged. This also holds when the FIFO is full or empty; an empty FIFO with simultaneous en/done is an orphan, because the pop sees the pre-push state.
- Ack: X_ack[i]=1 clears X_vld[i] the next cycle. Ack while vld=0 is ignored. Slot data is held after ack.
- Done for slot t while X_vld[t]=1 and X_ack[t]=0: overwrite the data, vld stays 1, set X_ovf[t].
- Done and ack for the same slot in the same cycle: new data is loaded, vld stays 1, no overflow.
- Vec and rot paths are fully independent; simultaneous events on both are legal.
- flush: synchronous. Clears pointers, counts, vld, ovf and err. Strobes in the flush cycle are ignored. Data registers are retained.
- busy = (vec_count != 0) | (rot_count != 0).
- Results are passed through unmodified (no scaling, no sign change).
- Reset mid-operation: all in-flight tags are lost. Later done strobes are orphans.

Test Plan:
- Single op: block=01, vec_en pulse, done 18 cycles later with xout=0x1234, angle=0x2000 -> vec_vld=0010 one cycle after done, slot1 mag=0x1234, angle=0x2000; vec_ack[1] -> vld=0000 next cycle.
- Out-of-order clients: rot issues from blocks 00, 11, 10 on consecutive cycles, three dones with yout 1, 2, 3 -> rot_yout slot0=1, slot3=2, slot2=3; rot_vld=1101; busy falls after the third done.
- Overflow: two vec issues from block 10, two dones without ack -> second data visible, vec_ovf=0100. Repeat with ack on the second done cycle -> ovf stays 0000, vld=0100.
- Full FIFO: 4 issues plus a 5th with no done -> err_tagfull=1, 4 dones route correctly, 5th done -> err_orphan=1. Then full FIFO with issue and done in the same cycle -> no error, count stays 4.
- Independence: vec_done and rot_done in the same cycle for different clients -> both slots valid, no cross-corruption.
- Reset/flush: rst asserted with 2 tags in flight -> all outputs 0 immediately. flush with vld=1111 -> vld=0000 and flags cleared the next cycle, data unchanged.

Source files
------------

// File: rtl/cordic_result_router.sv
// Return path of the shared CORDIC: per-mode tag FIFOs record the issuing client,
// and results are routed into per-client holding registers with a valid/ack handshake.
module cordic_result_router #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ANGLE_WIDTH   = 16,
    parameter int unsigned CORDIC_STAGES = 16,
    parameter int unsigned TAG_DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 block,
    input  logic                       flush,
    input  logic                       cordic_vec_en,
    input  logic                       cordic_rot_en,
    input  logic                       cordic_vec_done,
    input  logic [DATA_WIDTH-1:0]      cordic_vec_xout,
    input  logic [ANGLE_WIDTH-1:0]     cordic_vec_angle_out,
    input  logic [CORDIC_STAGES-1:0]   cordic_vec_microRot_out,
    input  logic                       cordic_rot_done,
    input  logic [DATA_WIDTH-1:0]      cordic_rot_xout,
    input  logic [DATA_WIDTH-1:0]      cordic_rot_yout,
    input  logic [3:0]                 vec_ack,
    input  logic [3:0]                 rot_ack,
    output logic [3:0]                 vec_vld,
    output logic [4*DATA_WIDTH-1:0]    vec_mag,
    output logic [4*ANGLE_WIDTH-1:0]   vec_angle,
    output logic [4*CORDIC_STAGES-1:0] vec_microRot,
    output logic [3:0]                 rot_vld,
    output logic [4*DATA_WIDTH-1:0]    rot_xout,
    output logic [4*DATA_WIDTH-1:0]    rot_yout,
    output logic [3:0]                 vec_ovf,
    output logic [3:0]                 rot_ovf,
    output logic                       err_tagfull,
    output logic                       err_orphan,
    output logic                       busy
);
    localparam int unsigned PW = $clog2(TAG_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [1:0]    vec_tags [TAG_DEPTH];
    logic [1:0]    rot_tags [TAG_DEPTH];
    logic [PW-1:0] vec_wptr, vec_rptr, rot_wptr, rot_rptr;
    logic [CW-1:0] vec_cnt, rot_cnt;

    logic vec_full, vec_empty, rot_full, rot_empty;
    logic vec_push, vec_pop, rot_push, rot_pop;
    logic [3:0] vec_load, rot_load;

    // Pop is evaluated on the pre-push state; a pop frees room for a same-cycle push.
    always_comb begin
        vec_full  = (vec_cnt == CW'(TAG_DEPTH));
        vec_empty = (vec_cnt == '0);
        rot_full  = (rot_cnt == CW'(TAG_DEPTH));
        rot_empty = (rot_cnt == '0);
        vec_pop   = cordic_vec_done & ~vec_empty & ~flush;
        rot_pop   = cordic_rot_done & ~rot_empty & ~flush;
        vec_push  = cordic_vec_en & (~vec_full | vec_pop) & ~flush;
        rot_push  = cordic_rot_en & (~rot_full | rot_pop) & ~flush;
        vec_load  = vec_pop ? (4'b0001 << vec_tags[vec_rptr]) : 4'b0000;
        rot_load  = rot_pop ? (4'b0001 << rot_tags[rot_rptr]) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (vec_push) vec_tags[vec_wptr] <= block;
        if (rot_push) rot_tags[rot_wptr] <= block;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_wptr    <= '0;
            vec_rptr    <= '0;
            vec_cnt     <= '0;
            rot_wptr    <= '0;
            rot_rptr    <= '0;
            rot_cnt     <= '0;
            vec_vld     <= '0;
            rot_vld     <= '0;
            vec_ovf     <= '0;
            rot_ovf     <= '0;
            err_tagfull <= 1'b0;
            err_orphan  <= 1'b0;
        end else if (flush) begin
            vec_wptr    <= '0;
            vec_rptr    <= '0;
            vec_cnt     <= '0;
            rot_wptr    <= '0;
            rot_rptr    <= '0;
            rot_cnt     <= '0;
            vec_vld     <= '0;
            rot_vld     <= '0;
            vec_ovf     <= '0;
            rot_ovf     <= '0;
            err_tagfull <= 1'b0;
            err_orphan  <= 1'b0;
        end else begin
            if (vec_push) vec_wptr <= vec_wptr + 1'b1;
            if (vec_pop)  vec_rptr <= vec_rptr + 1'b1;
            if (rot_push) rot_wptr <= rot_wptr + 1'b1;
            if (rot_pop)  rot_rptr <= rot_rptr + 1'b1;
            vec_cnt <= vec_cnt + CW'(vec_push) - CW'(vec_pop);
            rot_cnt <= rot_cnt + CW'(rot_push) - CW'(rot_pop);
            // A same-cycle ack consumes the old result, so the reload is not an overflow.
            vec_vld <= vec_load | (vec_vld & ~vec_ack);
            rot_vld <= rot_load | (rot_vld & ~rot_ack);
            vec_ovf <= vec_ovf | (vec_load & vec_vld & ~vec_ack);
            rot_ovf <= rot_ovf | (rot_load & rot_vld & ~rot_ack);
            err_tagfull <= err_tagfull | (cordic_vec_en & vec_full & ~vec_pop)
                                       | (cordic_rot_en & rot_full & ~rot_pop);
            err_orphan  <= err_orphan | (cordic_vec_done & vec_empty)
                                      | (cordic_rot_done & rot_empty);
        end
    end

    // Result data survives flush; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_mag      <= '0;
            vec_angle    <= '0;
            vec_microRot <= '0;
            rot_xout     <= '0;
            rot_yout     <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (vec_load[i]) begin
                    vec_mag[i*DATA_WIDTH +: DATA_WIDTH]          <= cordic_vec_xout;
                    vec_angle[i*ANGLE_WIDTH +: ANGLE_WIDTH]      <= cordic_vec_angle_out;
                    vec_microRot[i*CORDIC_STAGES +: CORDIC_STAGES] <= cordic_vec_microRot_out;
                end
                if (rot_load[i]) begin
                    rot_xout[i*DATA_WIDTH +: DATA_WIDTH] <= cordic_rot_xout;
                    rot_yout[i*DATA_WIDTH +: DATA_WIDTH] <= cordic_rot_yout;
                end
            end
        end
    end

    assign busy = (vec_cnt != '0) | (rot_cnt != '0);

endmodule

// File: tb/tb_cordic_result_router.sv
// Bench for cordic_result_router: tag-queue scoreboard for result routing plus
// table-driven single-op vectors and hand sequences for FIFO, overflow and reset corners.
module tb_cordic_result_router;
    localparam int DW = 16;
    localparam int TD = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      block;
    logic            flush;
    logic            cordic_vec_en, cordic_rot_en, cordic_vec_done, cordic_rot_done;
    logic [DW-1:0]   cordic_vec_xout, cordic_vec_angle_out, cordic_vec_microRot_out;
    logic [DW-1:0]   cordic_rot_xout, cordic_rot_yout;
    logic [3:0]      vec_ack, rot_ack, vec_vld, rot_vld, vec_ovf, rot_ovf;
    logic [4*DW-1:0] vec_mag, vec_angle, vec_microRot, rot_xout, rot_yout;
    logic            err_tagfull, err_orphan, busy;

    cordic_result_router #(
        .DATA_WIDTH(DW), .ANGLE_WIDTH(DW), .CORDIC_STAGES(DW), .TAG_DEPTH(TD)
    ) dut (
        .clk(clk), .rst(rst), .block(block), .flush(flush),
        .cordic_vec_en(cordic_vec_en), .cordic_rot_en(cordic_rot_en),
        .cordic_vec_done(cordic_vec_done), .cordic_vec_xout(cordic_vec_xout),
        .cordic_vec_angle_out(cordic_vec_angle_out),
        .cordic_vec_microRot_out(cordic_vec_microRot_out),
        .cordic_rot_done(cordic_rot_done), .cordic_rot_xout(cordic_rot_xout),
        .cordic_rot_yout(cordic_rot_yout), .vec_ack(vec_ack), .rot_ack(rot_ack),
        .vec_vld(vec_vld), .vec_mag(vec_mag), .vec_angle(vec_angle),
        .vec_microRot(vec_microRot), .rot_vld(rot_vld), .rot_xout(rot_xout),
        .rot_yout(rot_yout), .vec_ovf(vec_ovf), .rot_ovf(rot_ovf),
        .err_tagfull(err_tagfull), .err_orphan(err_orphan), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] slot; logic [DW-1:0] a; logic [DW-1:0] b; logic [DW-1:0] c; } exp_t;
    typedef struct { logic [1:0] blk; logic [DW-1:0] mag; logic [DW-1:0] ang; logic [DW-1:0] mr;
                     logic [3:0] exp_vld; int gap; } vec_rec_t;

    int checks = 0;
    int errors = 0;
    logic [1:0] mvq [$];
    logic [1:0] mrq [$];
    exp_t vexp_q [$];
    exp_t rexp_q [$];
    logic [DW-1:0] vmag_last [4];
    vec_rec_t tbl [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clr();
        cordic_vec_en = 0; cordic_rot_en = 0; cordic_vec_done = 0; cordic_rot_done = 0;
        vec_ack = 0; rot_ack = 0; flush = 0;
    endtask

    // One clock: update the tag-queue model, clock the DUT, then compare routed results.
    task automatic step();
        exp_t e;
        if (flush) begin
            mvq.delete();
            mrq.delete();
        end else begin
            if (cordic_vec_done && mvq.size() > 0)
                vexp_q.push_back('{mvq.pop_front(), cordic_vec_xout, cordic_vec_angle_out,
                                   cordic_vec_microRot_out});
            if (cordic_rot_done && mrq.size() > 0)
                rexp_q.push_back('{mrq.pop_front(), cordic_rot_xout, cordic_rot_yout, '0});
            if (cordic_vec_en && mvq.size() < TD) mvq.push_back(block);
            if (cordic_rot_en && mrq.size() < TD) mrq.push_back(block);
        end
        @(posedge clk);
        #1;
        clr();
        while (vexp_q.size() > 0) begin
            e = vexp_q.pop_front();
            check("vec_mag", 64'(vec_mag[int'(e.slot)*DW +: DW]), 64'(e.a));
            check("vec_angle", 64'(vec_angle[int'(e.slot)*DW +: DW]), 64'(e.b));
            check("vec_microRot", 64'(vec_microRot[int'(e.slot)*DW +: DW]), 64'(e.c));
            check("vec_vld_slot", 64'(vec_vld[e.slot]), 64'(1));
            vmag_last[e.slot] = e.a;
        end
        while (rexp_q.size() > 0) begin
            e = rexp_q.pop_front();
            check("rot_xout", 64'(rot_xout[int'(e.slot)*DW +: DW]), 64'(e.a));
            check("rot_yout", 64'(rot_yout[int'(e.slot)*DW +: DW]), 64'(e.b));
            check("rot_vld_slot", 64'(rot_vld[e.slot]), 64'(1));
        end
    endtask

    task automatic vissue(input logic [1:0] b);
        block = b; cordic_vec_en = 1; step();
    endtask

    task automatic vdone(input logic [DW-1:0] m);
        cordic_vec_done = 1; cordic_vec_xout = m; cordic_vec_angle_out = ~m;
        cordic_vec_microRot_out = m ^ 16'h5A5A; step();
    endtask

    task automatic do_flush();
        flush = 1; step();
    endtask

    task automatic check_data_kept();
        for (int i = 0; i < 4; i++)
            check("data_kept", 64'(vec_mag[i*DW +: DW]), 64'(vmag_last[i]));
    endtask

    initial begin
        tbl[0] = '{2'd1, 16'h1234, 16'h2000, 16'h00AA, 4'b0010, 17};
        tbl[1] = '{2'd0, 16'h8001, 16'h7FFF, 16'hFFFF, 4'b0001, 2};
        tbl[2] = '{2'd3, 16'hFFFF, 16'h0001, 16'h0000, 4'b1000, 0};
        tbl[3] = '{2'd2, 16'h0000, 16'h8000, 16'h1357, 4'b0100, 5};
        for (int i = 0; i < 4; i++) vmag_last[i] = '0;
        clr();
        block = 0; cordic_vec_xout = 0; cordic_vec_angle_out = 0; cordic_vec_microRot_out = 0;
        cordic_rot_xout = 0; cordic_rot_yout = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vec_vld", 64'(vec_vld), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_vec_mag", 64'(vec_mag), 64'(0));
        check("rst_errs", 64'({err_tagfull, err_orphan}), 64'(0));
        rst = 0;
        @(posedge clk);
        #1;

        // Single operations from each client
        for (int i = 0; i < 4; i++) begin
            block = tbl[i].blk; cordic_vec_en = 1; step();
            repeat (tbl[i].gap) step();
            cordic_vec_done = 1; cordic_vec_xout = tbl[i].mag;
            cordic_vec_angle_out = tbl[i].ang; cordic_vec_microRot_out = tbl[i].mr;
            step();
            check("tbl_vld", 64'(vec_vld), 64'(tbl[i].exp_vld));
            check("tbl_mag", 64'(vec_mag[int'(tbl[i].blk)*DW +: DW]), 64'(tbl[i].mag));
            check("tbl_busy", 64'(busy), 64'(0));
            vec_ack = tbl[i].exp_vld; step();
            check("tbl_ack_vld", 64'(vec_vld), 64'(0));
        end

        // Rotation results routed to out-of-order clients
        block = 0; cordic_rot_en = 1; step();
        block = 3; cordic_rot_en = 1; step();
        block = 2; cordic_rot_en = 1; step();
        for (int i = 1; i <= 3; i++) begin
            check("ooo_busy_before", 64'(busy), 64'(1));
            cordic_rot_done = 1; cordic_rot_xout = 16'(i * 256); cordic_rot_yout = 16'(i);
            step();
        end
        check("ooo_rot_vld", 64'(rot_vld), 64'(4'b1101));
        check("ooo_slot3_y", 64'(rot_yout[3*DW +: DW]), 64'(2));
        check("ooo_busy_after", 64'(busy), 64'(0));
        rot_ack = 4'b1111; step();

        // Overflow without ack, then reload with a same-cycle ack
        vissue(2); vissue(2); vdone(16'h1111); vdone(16'h2222);
        check("ovf_vld", 64'(vec_vld), 64'(4'b0100));
        check("ovf_set", 64'(vec_ovf), 64'(4'b0100));
        do_flush();
        check("ovf_flush", 64'({vec_ovf, vec_vld}), 64'(0));
        vissue(2); vissue(2); vdone(16'h3333);
        vec_ack = 4'b0100; vdone(16'h4444);
        check("ack_reload_ovf", 64'(vec_ovf), 64'(0));
        check("ack_reload_vld", 64'(vec_vld), 64'(4'b0100));
        vec_ack = 4'b0100; step();

        // Full tag FIFO and orphan done
        for (int i = 0; i < 4; i++) vissue(2'(i));
        check("full_no_err", 64'(err_tagfull), 64'(0));
        vissue(1);
        check("tagfull", 64'(err_tagfull), 64'(1));
        for (int i = 0; i < 4; i++) vdone(16'hA000 + 16'(i));
        check("full_vld", 64'(vec_vld), 64'(4'b1111));
        check("no_orphan", 64'(err_orphan), 64'(0));
        vdone(16'hAAAA);
        check("orphan", 64'(err_orphan), 64'(1));
        do_flush();
        check("flush_vld", 64'(vec_vld), 64'(0));
        check("flush_errs", 64'({err_tagfull, err_orphan}), 64'(0));
        check_data_kept();

        // Full FIFO with push and pop together keeps four entries
        for (int i = 0; i < 4; i++) vissue(2'(i));
        block = 2; cordic_vec_en = 1; vdone(16'hB000);
        check("fullpp_errs", 64'({err_tagfull, err_orphan}), 64'(0));
        for (int i = 1; i <= 3; i++) vdone(16'hB000 + 16'(i));
        check("fullpp_busy3", 64'(busy), 64'(1));
        vdone(16'hB004);
        check("fullpp_busy4", 64'(busy), 64'(0));
        check("fullpp_ovf", 64'(vec_ovf), 64'(4'b0100));
        do_flush();

        // Empty FIFO with issue and done together is an orphan
        block = 3; cordic_vec_en = 1; vdone(16'hC000);
        check("empty_pp_orphan", 64'(err_orphan), 64'(1));
        check("empty_pp_busy", 64'(busy), 64'(1));
        check("empty_pp_vld", 64'(vec_vld), 64'(0));
        vdone(16'hC001);
        check("empty_pp_vld3", 64'(vec_vld), 64'(4'b1000));
        do_flush();

        // Simultaneous vec and rot completions
        vissue(0);
        block = 3; cordic_rot_en = 1; step();
        cordic_rot_done = 1; cordic_rot_xout = 16'hD00D; cordic_rot_yout = 16'hBEEF;
        vdone(16'hCAFE);
        check("indep_vec_vld", 64'(vec_vld), 64'(4'b0001));
        check("indep_rot_vld", 64'(rot_vld), 64'(4'b1000));

        // Flush with all vec slots valid
        for (int i = 0; i < 4; i++) vissue(2'(i));
        for (int i = 0; i < 4; i++) vdone(16'hE000 + 16'(i));
        check("all_vld", 64'(vec_vld), 64'(4'b1111));
        do_flush();
        check("flush_all_vld", 64'(vec_vld), 64'(0));
        check_data_kept();

        // Asynchronous reset with tags in flight
        vissue(1); vissue(2);
        check("inflight_busy", 64'(busy), 64'(1));
        rst = 1;
        #1;
        check("arst_vld", 64'({vec_vld, rot_vld}), 64'(0));
        check("arst_data", 64'(vec_mag | rot_yout), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        mvq.delete(); mrq.delete();
        for (int i = 0; i < 4; i++) vmag_last[i] = '0;
        #2 rst = 0;
        @(posedge clk);
        #1;
        vdone(16'hF00F);
        check("post_rst_orphan", 64'(err_orphan), 64'(1));
        check("post_rst_vld", 64'(vec_vld), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
